// File: rtl/ysyx_22050550_div_pkg.sv
// Shared constants for the iterative EXU divider: FSM encoding, word width
// and the iteration counter sizing rule.
package ysyx_22050550_div_pkg;

    localparam int unsigned W32 = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned BPC_DEF   = 1;
    localparam int unsigned CNT_W_DEF = $clog2(XLEN_DEF / BPC_DEF);

    // Counter must hold XLEN/BPC - 1, the longest (full-width) iteration count.
    function automatic int unsigned cnt_width(input int unsigned xlen, input int unsigned bpc);
        return $clog2(xlen / bpc);
    endfunction

    typedef struct packed {
        logic word;
        logic q_neg;
        logic r_neg;
    } div_ctl_t;

endpackage

// File: rtl/ysyx_22050550_div_step.sv
// One restoring division step: shift in the next dividend bit and subtract
// the divisor when the shifted partial remainder is large enough.
module ysyx_22050550_div_step
    import ysyx_22050550_div_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            bit_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem_i < divisor keeps |diff| below 2^XLEN, so the top bit is the borrow.
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, divisor_i};
    assign q_o     = ~diff[XLEN];
    assign rem_o   = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/ysyx_22050550_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU and their W forms, with
// RISC-V divide-by-zero/overflow fast paths and a held valid/ready result.
module ysyx_22050550_div_unit
    import ysyx_22050550_div_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned BPC  = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_Exu_DivValid,
    output logic            io_Exu_DivReady,
    input  logic            io_Exu_Divw,
    input  logic            io_Exu_DivSigned,
    input  logic [XLEN-1:0] io_Exu_Divdend,
    input  logic [XLEN-1:0] io_Exu_Divisor,
    input  logic            io_Exu_Flush,
    output logic            io_Exu_OutValid,
    input  logic            io_Exu_OutReady,
    output logic [XLEN-1:0] io_Exu_Quotient,
    output logic [XLEN-1:0] io_Exu_Remainder
);

    localparam int unsigned CNT_W = cnt_width(XLEN, BPC);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  q_out_q, q_out_d, r_out_q, r_out_d;
    div_ctl_t         ctl_q, ctl_d;
    logic [XLEN-1:0]  dvd_q, dvd_d, dsr_q, dsr_d, rem_q, rem_d, quo_q, quo_d;

    logic [XLEN-1:0] wmask, sign_min, a_w, b_w, a_abs, b_abs;
    logic            a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0] rem_chain [0:BPC];
    logic [BPC-1:0]  q_bits;
    logic [XLEN-1:0] q_raw, r_raw, q_fix, r_fix;

    function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] v, input logic word);
        return word ? XLEN'($signed(v[W32-1:0])) : v;
    endfunction

    // Operand decode on the request: W-bit view, signs and magnitudes.
    assign wmask    = io_Exu_Divw ? XLEN'(32'hFFFF_FFFF) : '1;
    assign sign_min = io_Exu_Divw ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    assign a_w      = io_Exu_Divdend & wmask;
    assign b_w      = io_Exu_Divisor & wmask;
    assign a_neg    = io_Exu_DivSigned & (io_Exu_Divw ? io_Exu_Divdend[W32-1] : io_Exu_Divdend[XLEN-1]);
    assign b_neg    = io_Exu_DivSigned & (io_Exu_Divw ? io_Exu_Divisor[W32-1] : io_Exu_Divisor[XLEN-1]);
    assign a_abs    = (a_neg ? -a_w : a_w) & wmask;
    assign b_abs    = (b_neg ? -b_w : b_w) & wmask;
    assign div_zero = (b_w == '0);
    assign ovf      = io_Exu_DivSigned && (a_w == sign_min) && (b_w == wmask);

    assign rem_chain[0] = rem_q;
    for (genvar k = 0; k < BPC; k++) begin : g_step
        ysyx_22050550_div_step #(.XLEN(XLEN)) u_step (
            .rem_i     (rem_chain[k]),
            .divisor_i (dsr_q),
            .bit_i     (dvd_q[XLEN-1-k]),
            .rem_o     (rem_chain[k+1]),
            .q_o       (q_bits[BPC-1-k])
        );
    end

    assign q_raw = {quo_q[XLEN-1-BPC:0], q_bits};
    assign r_raw = rem_chain[BPC];
    assign q_fix = ctl_q.q_neg ? -q_raw : q_raw;
    assign r_fix = ctl_q.r_neg ? -r_raw : r_raw;

    always_comb begin
        // NOTE: every next-state value gets a hold default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        ctl_d   = ctl_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        if (io_Exu_Flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (io_Exu_DivValid) begin
                    ctl_d.word  = io_Exu_Divw;
                    ctl_d.q_neg = a_neg ^ b_neg;
                    ctl_d.r_neg = a_neg;
                    cnt_d = io_Exu_Divw ? CNT_W'(W32 / BPC - 1) : CNT_W'(XLEN / BPC - 1);
                    dvd_d = io_Exu_Divw ? (a_abs << (XLEN - W32)) : a_abs;
                    dsr_d = b_abs;
                    rem_d = '0;
                    quo_d = '0;
                    if (div_zero) begin
                        state_d = S_DONE;
                        q_out_d = '1;
                        r_out_d = fit(a_w, io_Exu_Divw);
                    end else if (ovf) begin
                        state_d = S_DONE;
                        q_out_d = fit(a_w, io_Exu_Divw);
                        r_out_d = '0;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    dvd_d = dvd_q << BPC;
                    quo_d = q_raw;
                    rem_d = r_raw;
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                        q_out_d = fit(q_fix, ctl_q.word);
                        r_out_d = fit(r_fix, ctl_q.word);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_DONE: if (io_Exu_OutReady) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            q_out_q <= '0;
            r_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
        end
    end

    // NOTE: datapath registers are left unreset; they are always loaded at accept before use.
    always_ff @(posedge clock) begin
        ctl_q <= ctl_d;
        dvd_q <= dvd_d;
        dsr_q <= dsr_d;
        rem_q <= rem_d;
        quo_q <= quo_d;
    end

    assign io_Exu_DivReady  = (state_q == S_IDLE);
    assign io_Exu_OutValid  = (state_q == S_DONE);
    assign io_Exu_Quotient  = q_out_q;
    assign io_Exu_Remainder = r_out_q;

endmodule

// File: tb/tb_ysyx_22050550_div_unit.sv
// Self-checking bench: a BPC=1 and a BPC=2 divider share the request inputs;
// results are compared against directed constants and an arithmetic model.
module tb_ysyx_22050550_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        div_valid, divw, dsigned, flush, out_ready;
    logic [63:0] dividend, divisor;
    logic        ready1, valid1, ready2, valid2;
    logic [63:0] quo1, rem1, quo2, rem2;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    ysyx_22050550_div_unit #(.XLEN(64), .BPC(1)) u_dut1 (
        .clock            (clock),
        .reset            (reset),
        .io_Exu_DivValid  (div_valid),
        .io_Exu_DivReady  (ready1),
        .io_Exu_Divw      (divw),
        .io_Exu_DivSigned (dsigned),
        .io_Exu_Divdend   (dividend),
        .io_Exu_Divisor   (divisor),
        .io_Exu_Flush     (flush),
        .io_Exu_OutValid  (valid1),
        .io_Exu_OutReady  (out_ready),
        .io_Exu_Quotient  (quo1),
        .io_Exu_Remainder (rem1)
    );

    ysyx_22050550_div_unit #(.XLEN(64), .BPC(2)) u_dut2 (
        .clock            (clock),
        .reset            (reset),
        .io_Exu_DivValid  (div_valid),
        .io_Exu_DivReady  (ready2),
        .io_Exu_Divw      (divw),
        .io_Exu_DivSigned (dsigned),
        .io_Exu_Divdend   (dividend),
        .io_Exu_Divisor   (divisor),
        .io_Exu_Flush     (flush),
        .io_Exu_OutValid  (valid2),
        .io_Exu_OutReady  (out_ready),
        .io_Exu_Quotient  (quo2),
        .io_Exu_Remainder (rem2)
    );

    // RISC-V division semantics from plain arithmetic.
    function automatic void ref_div(input logic [63:0] a, b, input logic w, s,
                                    output logic [63:0] q, r, output bit fast);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur;
        fast = 1'b0;
        if (w) begin
            if (s) begin
                sa = longint'($signed(a[31:0]));
                sb = longint'($signed(b[31:0]));
                if (sb == 0) begin
                    sq = -1; sr = sa; fast = 1'b1;
                end else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                    sq = sa; sr = 0; fast = 1'b1;
                end else begin
                    sq = sa / sb; sr = sa % sb;
                end
                uq = sq; ur = sr;
            end else begin
                ua = {32'h0, a[31:0]};
                ub = {32'h0, b[31:0]};
                if (ub == 0) begin
                    uq = 64'hFFFF_FFFF; ur = ua; fast = 1'b1;
                end else begin
                    uq = ua / ub; ur = ua % ub;
                end
            end
            q = {{32{uq[31]}}, uq[31:0]};
            r = {{32{ur[31]}}, ur[31:0]};
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            if (sb == 0) begin
                q = '1; r = a; fast = 1'b1;
            end else if (a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = '0; fast = 1'b1;
            end else begin
                sq = sa / sb; sr = sa % sb;
                q = sq; r = sr;
            end
        end else begin
            if (b == 0) begin
                q = '1; r = a; fast = 1'b1;
            end else begin
                q = a / b; r = a % b;
            end
        end
    endfunction

    function automatic void sample(input int sel, output logic v, rdy, output logic [63:0] q, r);
        v   = (sel == 2) ? valid2 : valid1;
        rdy = (sel == 2) ? ready2 : ready1;
        q   = (sel == 2) ? quo2 : quo1;
        r   = (sel == 2) ? rem2 : rem1;
    endfunction

    // Issue one op to both units, observe the selected one, then flush both back to IDLE.
    task automatic do_op(input int sel, input logic [63:0] a, b, input logic w, s,
                         input logic [63:0] exp_q, exp_r, input int exp_edges,
                         input int stall, input string tag);
        int          edges;
        logic        v, rdy;
        logic [63:0] q, r;
        div_valid = 1'b1; dividend = a; divisor = b; divw = w; dsigned = s; out_ready = 1'b0;
        @(posedge clock); #1;
        div_valid = 1'b0;
        dividend  = {$urandom, $urandom};
        divisor   = {$urandom, $urandom};
        divw      = 1'($urandom);
        dsigned   = 1'($urandom);
        sample(sel, v, rdy, q, r);
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: DivReady=%b after accept, want 0", tag, rdy);
        end
        edges = 0;
        while (v !== 1'b1 && edges < 200) begin
            @(posedge clock); #1;
            edges++;
            sample(sel, v, rdy, q, r);
        end
        checks++;
        if (edges !== exp_edges) begin
            errors++;
            $display("FAIL %s latency: OutValid at T+%0d, want T+%0d", tag, edges + 1, exp_edges + 1);
        end
        checks++;
        if (q !== exp_q) begin
            errors++;
            $display("FAIL %s quotient: got %h, want %h", tag, q, exp_q);
        end
        checks++;
        if (r !== exp_r) begin
            errors++;
            $display("FAIL %s remainder: got %h, want %h", tag, r, exp_r);
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clock); #1;
            sample(sel, v, rdy, q, r);
            checks++;
            if (v !== 1'b1 || rdy !== 1'b0 || q !== exp_q || r !== exp_r) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b ready=%b q=%h r=%h, want 1 0 %h %h",
                         tag, i, v, rdy, q, r, exp_q, exp_r);
            end
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        sample(sel, v, rdy, q, r);
        checks++;
        if (rdy !== 1'b1 || v !== 1'b0) begin
            errors++;
            $display("FAIL %s release: ready=%b valid=%b, want 1 0", tag, rdy, v);
        end
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (ready1 !== 1'b1 || valid1 !== 1'b0 || quo1 !== 64'h0 || rem1 !== 64'h0) begin
            errors++;
            $display("FAIL reset1: ready=%b valid=%b q=%h r=%h, want 1 0 0 0", ready1, valid1, quo1, rem1);
        end
        checks++;
        if (ready2 !== 1'b1 || valid2 !== 1'b0 || quo2 !== 64'h0 || rem2 !== 64'h0) begin
            errors++;
            $display("FAIL reset2: ready=%b valid=%b q=%h r=%h, want 1 0 0 0", ready2, valid2, quo2, rem2);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        do_op(1, 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 64, 0, "udiv64");
        do_op(1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 32, 0, "sdivw");
        do_op(1, 64'h1234, 64'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 0, 0, "divzero");
        do_op(2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
              64'h8000_0000_0000_0000, 64'h0, 0, 0, "overflow");
        do_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0,
              64'h5555_5555_5555_5555, 64'h0, 32, 0, "bpc2");
        do_op(1, 64'h0000_0000_8000_0000, 64'h0, 1'b1, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, 0, "divzerouw");
    endtask

    task automatic test_backpressure();
        do_op(1, 64'd1000, 64'd33, 1'b0, 1'b0, 64'd30, 64'd10, 64, 5, "backpressure");
    endtask

    task automatic test_flush();
        bit seen;
        div_valid = 1'b1; dividend = 64'd12345; divisor = 64'd11; divw = 1'b0; dsigned = 1'b0;
        @(posedge clock); #1;
        div_valid = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        checks++;
        if (ready1 !== 1'b1 || valid1 !== 1'b0 || ready2 !== 1'b1 || valid2 !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc: ready=%b/%b valid=%b/%b, want 1/1 0/0", ready1, ready2, valid1, valid2);
        end
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clock); #1;
            if (valid1 === 1'b1 || valid2 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_noresult: OutValid seen=%b, want 0", seen);
        end
        div_valid = 1'b1; flush = 1'b1; dividend = 64'd9; divisor = 64'd0;
        @(posedge clock); #1;
        div_valid = 1'b0; flush = 1'b0;
        checks++;
        if (ready1 !== 1'b1 || valid1 !== 1'b0) begin
            errors++;
            $display("FAIL flush_ignore: ready=%b valid=%b, want 1 0", ready1, valid1);
        end
    endtask

    task automatic test_reset_midop();
        div_valid = 1'b1; dividend = 64'd777; divisor = 64'd5; divw = 1'b0; dsigned = 1'b0;
        @(posedge clock); #1;
        div_valid = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if (ready1 !== 1'b1 || valid1 !== 1'b0 || quo1 !== 64'h0 || rem1 !== 64'h0) begin
            errors++;
            $display("FAIL reset_midop: ready=%b valid=%b q=%h r=%h, want 1 0 0 0", ready1, valid1, quo1, rem1);
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, q, r;
        logic        w, s;
        bit          fast;
        int          sel, kind;
        for (int n = 0; n < 40; n++) begin
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            w    = 1'($urandom);
            s    = 1'($urandom);
            sel  = $urandom_range(1, 2);
            kind = $urandom_range(0, 5);
            case (kind)
                1: b = 64'($urandom_range(1, 20));
                2: b = {$urandom, 32'h0};
                3: begin
                    s = 1'b1;
                    a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
                end
                4: b = -64'($urandom_range(1, 1000));
                5: a = 64'($urandom_range(0, 50));
                default: ;
            endcase
            ref_div(a, b, w, s, q, r, fast);
            do_op(sel, a, b, w, s, q, r, fast ? 0 : (w ? 32 : 64) / sel,
                  $urandom_range(0, 3), $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        div_valid = 1'b0; divw = 1'b0; dsigned = 1'b0; flush = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
